// File: rtl/lcd_char_ctrl_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | lcd_char_ctrl_if : frame handshake and HD44780 pin bundle          |
// | Rev 1.0                                                            |
// +------------------------------------------------------------------+
interface lcd_char_ctrl_if #(
    parameter int COLS = 16,
    parameter int ROWS = 2
);
    logic [8*COLS*ROWS-1:0] chars;
    logic                   frame_valid;
    logic                   frame_ready;
    logic                   busy;
    logic                   init_done;
    logic                   lcd_rs;
    logic                   lcd_rw;
    logic                   lcd_e;
    logic [3:0]             lcd_d;

    modport master (
        output chars, frame_valid,
        input  frame_ready, busy, init_done, lcd_rs, lcd_rw, lcd_e, lcd_d
    );

    modport slave (
        input  chars, frame_valid,
        output frame_ready, busy, init_done, lcd_rs, lcd_rw, lcd_e, lcd_d
    );
endinterface
`default_nettype wire

// File: rtl/lcd_char_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | lcd_char_ctrl : HD44780 4-bit init + full-frame character writer   |
// | Optional periodic rewrite when LCD_AUTO_REFRESH_EN is defined.     |
// | Rev 1.0                                                            |
// +------------------------------------------------------------------+
module lcd_char_ctrl #(
    parameter int CLK_HZ = 50_000_000,
    parameter int COLS   = 16,
    parameter int ROWS   = 2
) (
    input  wire logic        clk,
    input  wire logic        rst,
    lcd_char_ctrl_if.slave   bus
);
    function automatic int at_least_1(input longint v);
        return (v < 64'sd1) ? 1 : int'(v);
    endfunction

    localparam longint HZ       = longint'(CLK_HZ);
    localparam int     HB       = 8 * COLS * ROWS;
    localparam int     PWR_CYC  = at_least_1(HZ * 15 / 1000);
    localparam int     T_SU     = at_least_1(HZ / 10_000_000);
    localparam int     T_EH     = at_least_1(HZ / 1_000_000);
    localparam int     DLY_W    = (PWR_CYC > 2) ? $clog2(PWR_CYC) : 2;
    localparam int     COL_W    = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int     ROW_W    = (ROWS > 1) ? $clog2(ROWS) : 1;

    localparam logic [DLY_W-1:0] PWR_END   = DLY_W'(PWR_CYC - 1);
    localparam logic [DLY_W-1:0] SU_END    = DLY_W'(T_SU - 1);
    localparam logic [DLY_W-1:0] EH_END    = DLY_W'(T_EH - 1);
    localparam logic [DLY_W-1:0] G4100_END = DLY_W'(at_least_1(HZ * 41 / 10_000) - 1);
    localparam logic [DLY_W-1:0] G100_END  = DLY_W'(at_least_1(HZ / 10_000) - 1);
    localparam logic [DLY_W-1:0] G40_END   = DLY_W'(at_least_1(HZ * 4 / 100_000) - 1);
    localparam logic [DLY_W-1:0] G1640_END = DLY_W'(at_least_1(HZ * 164 / 100_000) - 1);

    typedef enum logic [2:0] {
        PWR_WAIT = 3'd0, INIT = 3'd1, IDLE = 3'd2,
        ROW_ADDR = 3'd3, CHAR = 3'd4, ROW_NEXT = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        TX_IDLE = 3'd0, TX_SU = 3'd1, TX_EH = 3'd2, TX_HD = 3'd3, TX_GAP = 3'd4
    } tx_t;

    state_t             state_q, state_d;
    tx_t                tx_q, tx_d;
    logic [DLY_W-1:0]   cnt_q, cnt_d, gap_end_q, gap_end_d;
    logic [7:0]         tx_byte_q, tx_byte_d;
    logic               tx_one_q, tx_one_d, tx_lo_q, tx_lo_d;
    logic [2:0]         step_q, step_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [HB-1:0]      hold_q, hold_d;
    logic               busy_q, busy_d, init_done_q, init_done_d;
    logic               e_q, e_d, rs_q, rs_d;
    logic [3:0]         d_q, d_d;

    logic               w_done, w_send, w_rs, w_one;
    logic [7:0]         w_byte, w_off;
    logic [DLY_W-1:0]   w_gap;

`ifdef LCD_AUTO_REFRESH_EN
    localparam int               REF_CYC = at_least_1(HZ / 10);
    localparam int               REF_W   = (REF_CYC > 2) ? $clog2(REF_CYC) : 2;
    localparam logic [REF_W-1:0] REF_END = REF_W'(REF_CYC - 1);
    logic [REF_W-1:0]            ref_q, ref_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ref_q <= '0;
        else     ref_q <= ref_d;
    end
`endif

    always_comb begin
        w_off = row_q[0] ? 8'h40 : 8'h00;
        if (int'(row_q) >= 2) w_off = w_off + 8'(COLS);
    end

    always_comb begin
        state_d = state_q;     tx_d = tx_q;           cnt_d = cnt_q;
        gap_end_d = gap_end_q; tx_byte_d = tx_byte_q; tx_one_d = tx_one_q;
        tx_lo_d = tx_lo_q;     step_d = step_q;       col_d = col_q;
        row_d = row_q;         hold_d = hold_q;       busy_d = busy_q;
        init_done_d = init_done_q;
        e_d = e_q;             rs_d = rs_q;           d_d = d_q;
        w_done = 1'b0;  w_send = 1'b0;  w_byte = 8'h00;
        w_rs = 1'b0;    w_one = 1'b0;   w_gap = G40_END;
`ifdef LCD_AUTO_REFRESH_EN
        ref_d = '0;
`endif

        // Nibble engine: setup, E pulse, hold, then (after the last nibble) the gap
        case (tx_q)
            TX_SU: if (cnt_q == SU_END) begin
                tx_d = TX_EH; cnt_d = '0; e_d = 1'b1;
            end else cnt_d = cnt_q + 1'b1;
            TX_EH: if (cnt_q == EH_END) begin
                tx_d = TX_HD; cnt_d = '0; e_d = 1'b0;
            end else cnt_d = cnt_q + 1'b1;
            TX_HD: if (cnt_q == SU_END) begin
                cnt_d = '0;
                if (!tx_one_q && !tx_lo_q) begin
                    tx_lo_d = 1'b1; d_d = tx_byte_q[3:0]; tx_d = TX_SU;
                end else tx_d = TX_GAP;
            end else cnt_d = cnt_q + 1'b1;
            TX_GAP: if (cnt_q == gap_end_q) begin
                tx_d = TX_IDLE; cnt_d = '0; w_done = 1'b1;
            end else cnt_d = cnt_q + 1'b1;
            default: ;
        endcase

        case (state_q)
            PWR_WAIT: if (cnt_q == PWR_END) begin
                cnt_d = '0; state_d = INIT;
            end else cnt_d = cnt_q + 1'b1;
            INIT: begin
                w_send = 1'b1;
                case (step_q)
                    3'd0:    begin w_byte = 8'h30; w_one = 1'b1; w_gap = G4100_END; end
                    3'd1:    begin w_byte = 8'h30; w_one = 1'b1; w_gap = G100_END;  end
                    3'd2:    begin w_byte = 8'h30; w_one = 1'b1; end
                    3'd3:    begin w_byte = 8'h20; w_one = 1'b1; end
                    3'd4:    w_byte = 8'h28;
                    3'd5:    w_byte = 8'h0C;
                    3'd6:    w_byte = 8'h06;
                    default: begin w_byte = 8'h01; w_gap = G1640_END; end
                endcase
                if (w_done) begin
                    if (step_q == 3'd7) begin
                        step_d = '0; init_done_d = 1'b1; busy_d = 1'b0; state_d = IDLE;
                    end else step_d = step_q + 1'b1;
                end
            end
            IDLE: begin
                // An offered frame takes priority over a coincident refresh expiry
                if (bus.frame_valid) begin
                    hold_d = bus.chars; busy_d = 1'b1; state_d = ROW_ADDR;
                end
`ifdef LCD_AUTO_REFRESH_EN
                else if (ref_q == REF_END) begin
                    busy_d = 1'b1; state_d = ROW_ADDR;
                end else ref_d = ref_q + 1'b1;
`endif
            end
            ROW_ADDR: begin
                w_send = 1'b1; w_byte = 8'h80 | w_off;
                if (w_done) state_d = CHAR;
            end
            CHAR: begin
                w_send = 1'b1; w_rs = 1'b1; w_byte = hold_q[HB-1 -: 8];
                if (w_done) begin
                    // Rotating leaves the hold register intact after a full frame
                    hold_d = (hold_q << 8) | (hold_q >> (HB - 8));
                    if (col_q == COL_W'(COLS - 1)) begin
                        col_d = '0; state_d = ROW_NEXT;
                    end else col_d = col_q + 1'b1;
                end
            end
            ROW_NEXT: if (row_q == ROW_W'(ROWS - 1)) begin
                row_d = '0; busy_d = 1'b0; state_d = IDLE;
            end else begin
                row_d = row_q + 1'b1; state_d = ROW_ADDR;
            end
            default: state_d = PWR_WAIT;
        endcase

        if (w_send && tx_q == TX_IDLE) begin
            tx_d = TX_SU;       cnt_d = '0;         tx_byte_d = w_byte;
            tx_one_d = w_one;   tx_lo_d = 1'b0;     gap_end_d = w_gap;
            d_d = w_byte[7:4];  rs_d = w_rs;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= PWR_WAIT;  tx_q <= TX_IDLE;     cnt_q <= '0;
            gap_end_q <= '0;      tx_byte_q <= '0;     tx_one_q <= 1'b0;
            tx_lo_q <= 1'b0;      step_q <= '0;        col_q <= '0;
            row_q <= '0;          hold_q <= {(HB/8){8'h20}};
            busy_q <= 1'b1;       init_done_q <= 1'b0;
            e_q <= 1'b0;          rs_q <= 1'b0;        d_q <= '0;
        end else begin
            state_q <= state_d;   tx_q <= tx_d;        cnt_q <= cnt_d;
            gap_end_q <= gap_end_d; tx_byte_q <= tx_byte_d; tx_one_q <= tx_one_d;
            tx_lo_q <= tx_lo_d;   step_q <= step_d;    col_q <= col_d;
            row_q <= row_d;       hold_q <= hold_d;
            busy_q <= busy_d;     init_done_q <= init_done_d;
            e_q <= e_d;           rs_q <= rs_d;        d_q <= d_d;
        end
    end

    assign bus.frame_ready = (state_q == IDLE);
    assign bus.busy        = busy_q;
    assign bus.init_done   = init_done_q;
    assign bus.lcd_rs      = rs_q;
    assign bus.lcd_rw      = 1'b0;
    assign bus.lcd_e       = e_q;
    assign bus.lcd_d       = d_q;
endmodule
`default_nettype wire

// File: tb/tb_lcd_char_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_lcd_char_ctrl : random-frame bench with a bus-level model       |
// | Rev 1.0                                                            |
// +------------------------------------------------------------------+
module tb_lcd_char_ctrl;
    localparam int CLK_HZ = 1_000_000;
    localparam int COLS   = 16;
    localparam int ROWS   = 2;
    localparam int NCH    = COLS * ROWS;
    localparam int HB     = 8 * NCH;

    logic clk;
    logic rst;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    lcd_char_ctrl_if #(.COLS(COLS), .ROWS(ROWS)) bus ();

    lcd_char_ctrl #(.CLK_HZ(CLK_HZ), .COLS(COLS), .ROWS(ROWS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic in_win(input int v, input int lo, input int hi);
        return (v >= lo) && (v <= hi);
    endfunction

    // Bus monitor: every E rising edge is one transferred nibble {rs, d}
    logic [4:0] mon_nib[$];
    int         mon_t[$];
    logic [4:0] exp_nib[$];
    logic       e_prev = 1'b0;
    int         e_rise_t = 0;

    always @(negedge clk) begin
        if (bus.lcd_e && !e_prev) begin
            mon_nib.push_back({bus.lcd_rs, bus.lcd_d});
            mon_t.push_back(cyc);
            e_rise_t = cyc;
        end
        if (!bus.lcd_e && e_prev && !rst) check_val("e_width", cyc - e_rise_t, 1);
        if (bus.frame_ready) check_val("ready_only_idle", bus.busy, 0);
        e_prev = bus.lcd_e;
    end

    task automatic push_byte(input logic [7:0] b, input logic rs);
        exp_nib.push_back({rs, b[7:4]});
        exp_nib.push_back({rs, b[3:0]});
    endtask

    // Reference: row address then the row's characters, straight from frame indexing
    task automatic model_frame(input logic [HB-1:0] f);
        for (int r = 0; r < ROWS; r++) begin
            push_byte(8'h80 | 8'((r % 2) * 64 + (r / 2) * COLS), 1'b0);
            for (int c = 0; c < COLS; c++)
                push_byte(f[HB-1-8*(r*COLS+c) -: 8], 1'b1);
        end
    endtask

    function automatic logic [HB-1:0] rand_frame(input bit printable);
        logic [HB-1:0] f;
        for (int i = 0; i < NCH; i++)
            f[i*8 +: 8] = printable ? 8'($urandom_range(32, 126)) : 8'($urandom);
        return f;
    endfunction

    task automatic clear_mon();
        mon_nib.delete();
        mon_t.delete();
        exp_nib.delete();
    endtask

    task automatic check_frames(input string tag);
        check_val({tag, "_count"}, mon_nib.size(), exp_nib.size());
        for (int i = 0; i < exp_nib.size() && i < mon_nib.size(); i++) begin
            check_val({tag, "_nib"}, mon_nib[i], exp_nib[i]);
            if (i % 2 == 1)
                check_val({tag, "_nib_gap"}, in_win(mon_t[i] - mon_t[i-1], 3, 6), 1);
            else if (i > 0)
                check_val({tag, "_byte_gap"}, in_win(mon_t[i] - mon_t[i-1], 43, 52), 1);
        end
        clear_mon();
    endtask

    task automatic run_init(input int t_rel);
        logic [4:0] exp_q[$];
        int n;
        int t_done;
        exp_q = '{5'h03, 5'h03, 5'h03, 5'h02, 5'h02, 5'h08,
                  5'h00, 5'h0C, 5'h00, 5'h06, 5'h00, 5'h01};
        repeat (10) @(negedge clk);
        check_val("init_busy", bus.busy, 1);
        check_val("init_done_early", bus.init_done, 0);
        n = 0;
        while (!bus.init_done && n < 40000) begin
            @(negedge clk);
            n++;
        end
        check_val("init_timeout", bus.init_done, 1);
        t_done = cyc;
        check_val("init_count", mon_nib.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < mon_nib.size(); i++)
            check_val("init_nib", mon_nib[i], exp_q[i]);
        if (mon_t.size() == 12) begin
            check_val("pwr_wait",  in_win(mon_t[0] - t_rel, 15000, 15010), 1);
            check_val("gap_4100",  in_win(mon_t[1] - mon_t[0], 4103, 4112), 1);
            check_val("gap_100",   in_win(mon_t[2] - mon_t[1], 103, 112), 1);
            check_val("gap_n3",    in_win(mon_t[3] - mon_t[2], 43, 52), 1);
            check_val("gap_n4",    in_win(mon_t[4] - mon_t[3], 43, 52), 1);
            for (int i = 5; i < 12; i++) begin
                if (i % 2 == 1) check_val("init_nib_gap",  in_win(mon_t[i] - mon_t[i-1], 3, 6), 1);
                else            check_val("init_byte_gap", in_win(mon_t[i] - mon_t[i-1], 43, 52), 1);
            end
            check_val("clear_gap", in_win(t_done - mon_t[11], 1642, 1650), 1);
        end
        check_val("idle_busy", bus.busy, 0);
        check_val("idle_ready", bus.frame_ready, 1);
        clear_mon();
    endtask

    // Offer f until accepted; afterwards either chain nxt as a new offer or scramble chars
    task automatic accept(input logic [HB-1:0] f, input bit chain, input logic [HB-1:0] nxt);
        int n;
        bus.chars       = f;
        bus.frame_valid = 1'b1;
        n = 0;
        while (!bus.frame_ready && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check_val("accept_timeout", bus.frame_ready, 1);
        @(posedge clk);
        #1;
        if (chain) bus.chars = nxt;
        else begin
            bus.frame_valid = 1'b0;
            bus.chars       = rand_frame(1'b0);
        end
        @(negedge clk);
        check_val("busy_after_accept", bus.busy, 1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (bus.busy && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check_val("write_timeout", bus.busy, 0);
    endtask

    task automatic write_frame(input logic [HB-1:0] f, input string tag);
        model_frame(f);
        accept(f, 1'b0, '0);
        wait_idle();
        check_frames(tag);
    endtask

    initial begin
        logic [HB-1:0] f;
        logic [HB-1:0] g;
        int n;
        rst             = 1'b1;
        bus.chars       = '0;
        bus.frame_valid = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_e",     bus.lcd_e, 0);
        check_val("rst_rs",    bus.lcd_rs, 0);
        check_val("rst_rw",    bus.lcd_rw, 0);
        check_val("rst_d",     bus.lcd_d, 0);
        check_val("rst_ready", bus.frame_ready, 0);
        check_val("rst_busy",  bus.busy, 1);
        check_val("rst_done",  bus.init_done, 0);
        rst = 1'b0;
        run_init(cyc);

        f = {"HELLO", {(NCH-5){8'h20}}};
        write_frame(f, "hello");
        repeat (3) write_frame(rand_frame(1'b1), "rand");

        // Frame offered throughout a write is taken once the block returns to idle
        f = rand_frame(1'b1);
        g = rand_frame(1'b1);
        model_frame(f);
        model_frame(g);
        accept(f, 1'b1, g);
        check_val("b2b_ready_busy", bus.frame_ready, 0);
        n = 0;
        while (!bus.frame_ready && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check_val("b2b_handshake", bus.frame_ready, 1);
        @(posedge clk);
        #1;
        bus.frame_valid = 1'b0;
        bus.chars       = rand_frame(1'b0);
        @(negedge clk);
        check_val("b2b_busy", bus.busy, 1);
        wait_idle();
        check_frames("b2b");
        repeat (3000) @(negedge clk);
        check_val("idle_quiet", mon_nib.size(), 0);

        // Reset while E is high
        accept(rand_frame(1'b1), 1'b0, '0);
        n = 0;
        while (!bus.lcd_e && n < 500) begin
            @(negedge clk);
            n++;
        end
        check_val("e_seen", bus.lcd_e, 1);
        rst = 1'b1;
        #1;
        check_val("arst_e",     bus.lcd_e, 0);
        check_val("arst_busy",  bus.busy, 1);
        check_val("arst_done",  bus.init_done, 0);
        check_val("arst_ready", bus.frame_ready, 0);
        repeat (5) @(negedge clk);
        clear_mon();
        rst = 1'b0;
        run_init(cyc);
        write_frame(rand_frame(1'b1), "post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
